// File: rtl/fft_input_packer.sv
// fft_input_packer: buffers one serial I/Q frame and bursts it to FFT stage 0
// as NPOINT/NLANE gap-free NLANE-lane blocks. Optional FFT_PACKER_IFFT_CONJ_EN.
// Ports: clk, rstn (async low); s_i/s_q/s_valid/s_last/s_ready sample stream;
// in_i/in_q/din_valid block output; frame_err pulse; busy while draining.
module fft_input_packer #(
  parameter int WIDTH  = 9,
  parameter int NLANE  = 16,
  parameter int NPOINT = 512
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [WIDTH-1:0] s_i,
  input  logic signed [WIDTH-1:0] s_q,
  input  logic                    s_valid,
  input  logic                    s_last,
`ifdef FFT_PACKER_IFFT_CONJ_EN
  input  logic                    fft_mode,
`endif
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] in_i [NLANE],
  output logic signed [WIDTH-1:0] in_q [NLANE],
  output logic                    din_valid,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int NBLK = NPOINT / NLANE;
  localparam int AW   = $clog2(NPOINT);
  localparam int LW   = $clog2(NLANE);
  localparam int BW   = AW - LW;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   scnt_q, scnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            rdy_q, rdy_d;
  logic            dv_q, dv_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            load;
  logic            hs;

  logic signed [WIDTH-1:0] mem_i [NPOINT];
  logic signed [WIDTH-1:0] mem_q [NPOINT];
  logic signed [WIDTH-1:0] rd_i  [NLANE];
  logic signed [WIDTH-1:0] rd_q  [NLANE];
  logic signed [WIDTH-1:0] blk_i_q [NLANE];
  logic signed [WIDTH-1:0] blk_q_q [NLANE];
  logic signed [WIDTH-1:0] wq;

  assign hs = s_valid & rdy_q & (state_q == FILL);

`ifdef FFT_PACKER_IFFT_CONJ_EN
  localparam logic signed [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  logic signed [WIDTH-1:0] negq;

  // Most-negative code has no positive twin; clamp it.
  assign negq = (s_q == SMIN) ? SMAX : -s_q;
  assign wq   = fft_mode ? negq : s_q;
`else
  assign wq = s_q;
`endif

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    rdy_d   = rdy_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = busy_q;
    load    = 1'b0;
    unique case (state_q)
      FILL: begin
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        if (hs) begin
          if (scnt_q == AW'(NPOINT-1)) begin
            // Block 0 goes out on the same edge that takes
            // the final sample, so the burst starts at T+1.
            state_d = DRAIN;
            scnt_d  = '0;
            bcnt_d  = '0;
            load    = 1'b1;
            dv_d    = 1'b1;
            rdy_d   = 1'b0;
            busy_d  = 1'b1;
            ferr_d  = ~s_last;
          end else if (s_last) begin
            ferr_d = 1'b1;
            scnt_d = '0;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bcnt_q == BW'(NBLK-1)) begin
          state_d = FILL;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
          load   = 1'b1;
          dv_d   = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < NLANE; k++) begin
      rd_i[k] = mem_i[{bcnt_d, LW'(k)}];
      rd_q[k] = mem_q[{bcnt_d, LW'(k)}];
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      mem_i[scnt_q] <= s_i;
      mem_q[scnt_q] <= wq;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      rdy_q   <= 1'b0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      rdy_q   <= rdy_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NLANE; k++) begin
        blk_i_q[k] <= '0;
        blk_q_q[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < NLANE; k++) begin
        blk_i_q[k] <= rd_i[k];
        blk_q_q[k] <= rd_q[k];
      end
    end
  end

  assign s_ready   = rdy_q;
  assign din_valid = dv_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
  assign in_i      = blk_i_q;
  assign in_q      = blk_q_q;

endmodule
